// File: rtl/mux16.sv
// Two-input word selector with a zero-latency combinational output and a
// one-cycle registered copy of both the selected word and the select line.
module mux16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
);

    // The conditional operator merges a and b bitwise when sel is X/Z,
    // which an if/else in always_comb would not do.
    assign out = sel ? b : a;

    // Registered copies; reset only touches these, never out.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux16.sv
// Self-checking bench for mux16: directed vectors plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mux16;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;

    int checks;
    int failures;

    // Reference state: what the registered outputs must hold after each edge.
    logic [WIDTH-1:0] m_out_q;
    logic             m_sel_q;
    logic             m_valid;

    mux16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .out_q (out_q),
        .sel_q (sel_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] xa,
                                              input logic [WIDTH-1:0] xb,
                                              input logic xs);
        if (xs) return xb;
        return xa;
    endfunction

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_out_q <= '0;
            m_sel_q <= 1'b0;
        end else begin
            m_out_q <= pick(a, b, sel);
            m_sel_q <= sel;
        end
        m_valid <= 1'b1;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        check("model_out", out, pick(a, b, sel));
        if (m_valid) begin
            check("model_out_q", out_q, m_out_q);
            check("model_sel_q", WIDTH'(sel_q), WIDTH'(m_sel_q));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1;
        a     = '0;
        b     = '0;
        sel   = 1'b0;

        // Reset state
        @(posedge clk); #1;
        check("reset_out_q", out_q, 16'h0000);
        check("reset_sel_q", WIDTH'(sel_q), 16'h0000);
        reset = 1'b0;

        // Combinational vectors, each sampled 1 time unit after the change
        @(posedge clk); #1;
        a = 16'h0000; b = 16'h0000; sel = 1'b0; #1 check("v0_sel0", out, 16'h0000);
        sel = 1'b1;                             #1 check("v0_sel1", out, 16'h0000);
        b = 16'h1234; sel = 1'b0;               #1 check("v1_sel0", out, 16'h0000);
        sel = 1'b1;                             #1 check("v1_sel1", out, 16'h1234);
        @(posedge clk); #1;
        a = 16'h9876; b = 16'h0000; sel = 1'b0; #1 check("v2_sel0", out, 16'h9876);
        sel = 1'b1;                             #1 check("v2_sel1", out, 16'h0000);
        a = 16'hAAAA; b = 16'h5555; sel = 1'b0; #1 check("v3_sel0", out, 16'hAAAA);
        sel = 1'b1;                             #1 check("v3_sel1", out, 16'h5555);

        // One-edge reset, then load after the next edge
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("r1_out_q", out_q, 16'h0000);
        check("r1_sel_q", WIDTH'(sel_q), 16'h0000);
        reset = 1'b0; a = 16'hAAAA; b = 16'h5555; sel = 1'b1;
        #1 check("r1_out_now", out, 16'h5555);
        check("r1_out_q_hold", out_q, 16'h0000);
        @(posedge clk); #1;
        check("r1_out_q_load", out_q, 16'h5555);
        check("r1_sel_q_load", WIDTH'(sel_q), 16'h0001);

        // Mid-cycle reset must not clear before the next edge
        reset = 1'b1;
        #1 check("mid_rst_out_q_hold", out_q, 16'h5555);
        check("mid_rst_sel_q_hold", WIDTH'(sel_q), 16'h0001);
        check("mid_rst_out", out, 16'h5555);
        @(posedge clk); #1;
        check("mid_rst_out_q_clr", out_q, 16'h0000);

        // Held reset with live data: out follows, out_q stays cleared
        a = 16'h9876; sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("held_rst_out", out, 16'h9876);
            @(posedge clk); #1;
            check("held_rst_out_q", out_q, 16'h0000);
        end
        reset = 1'b0;
        #1 check("rel_out_q_hold", out_q, 16'h0000);
        @(posedge clk); #1;
        check("rel_out_q_load", out_q, 16'h9876);
        check("rel_sel_q_load", WIDTH'(sel_q), 16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #2;
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            sel   = 1'($urandom);
            reset = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            compare_cycle();
            // Disturbing the unselected input must not affect out
            #1;
            if (sel) a = WIDTH'($urandom);
            else     b = WIDTH'($urandom);
            #1 check("unsel_disturb", out, pick(a, b, sel));
            check("hold_between_edges", out_q, m_out_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
